rr_job_dispatcher: RTL



---
 rtl/rr_job_dispatcher.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rr_job_dispatcher.sv
// ---------------------------------------------------------------------------
// rr_job_dispatcher
//
// Purpose:
//    Lets N requesters share one single-job processing engine.
//    The block does the following for each job:
//       - picks one pending requester in round-robin order;
//       - sends the engine a one-cycle start pulse;
//       - waits for the engine's done, with a timeout guard;
//       - sends the winner a one-cycle ack, then returns to arbitration.
//
// Parameters:
//    N        number of requesters (2..8)
//    TIMEOUT  maximum number of RUN cycles spent waiting for eng_done (>= 2)
//    CW       timeout counter width, 2^CW > TIMEOUT
//
// Ports:
//    clk          in   rising-edge clock
//    reset        in   synchronous, active-high reset
//    req          in   [N] level requests, held until acked
//    eng_start    out  one-cycle engine start pulse
//    eng_done     in   engine completion, only looked at in RUN
//    grant        out  [N] one-hot owner of the engine, zero when idle
//    ack          out  [N] one-cycle completion pulse to the owner
//    timeout_err  out  one-cycle pulse alongside ack when the job timed out
//    busy         out  high in every state except IDLE
//    state        out  [4] one-hot FSM state for debug
// ---------------------------------------------------------------------------
module rr_job_dispatcher #(
   parameter int N       = 4,
   parameter int TIMEOUT = 16,
   parameter int CW      = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   output logic         eng_start,
   input  logic         eng_done,
   output logic [N-1:0] grant,
   output logic [N-1:0] ack,
   output logic         timeout_err,
   output logic         busy,
   output logic [3:0]   state
);

   localparam int IW = $clog2(N);

   typedef enum logic [3:0] {
      S_IDLE   = 4'b0001,
      S_GRANT  = 4'b0010,
      S_RUN    = 4'b0100,
      S_FINISH = 4'b1000
   } state_e;

   state_e          state_q;
   logic [N-1:0]    grant_q;
   logic [IW-1:0]   gidx_q;
   logic [IW-1:0]   ptr_q;
   logic [CW-1:0]   cnt_q;
   logic            err_q;

   logic [IW-1:0]   pick_idx_d;
   logic [IW-1:0]   cand;

   // Round-robin search starting one past the last served index.
   // The loop walks from the farthest candidate to the nearest one,
   // so the last hit (the nearest set bit after ptr) is the one kept.
   always_comb begin
      pick_idx_d = '0;
      cand       = '0;
      for (int k = N; k >= 1; k--) begin
         cand = IW'((int'(ptr_q) + k) % N);
         if (req[cand]) begin
            pick_idx_d = cand;
         end
      end
   end

   // Job sequencing FSM. All outputs below are decoded from these
   // registers only, so no input reaches an output combinationally.
   // An illegal (non-one-hot) state falls into the default branch
   // and recovers to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= IW'(N - 1);
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req != '0) begin
                  grant_q <= {{(N-1){1'b0}}, 1'b1} << pick_idx_d;
                  gidx_q  <= pick_idx_d;
                  state_q <= S_GRANT;
               end
            end
            S_GRANT: begin
               cnt_q   <= '0;
               err_q   <= 1'b0;
               state_q <= S_RUN;
            end
            S_RUN: begin
               if (eng_done) begin
                  err_q   <= 1'b0;
                  state_q <= S_FINISH;
               end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                  err_q   <= 1'b1;
                  state_q <= S_FINISH;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_FINISH: begin
               ptr_q   <= gidx_q;
               grant_q <= '0;
               state_q <= S_IDLE;
            end
            default: begin
               grant_q <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign eng_start   = (state_q == S_GRANT);
   assign ack         = (state_q == S_FINISH) ? grant_q : '0;
   assign timeout_err = (state_q == S_FINISH) & err_q;
   assign busy        = (state_q != S_IDLE);
   assign grant       = grant_q;
   assign state       = state_q;

endmodule
